mips_instr_fetch: RTL and testbench

Multicycle MIPS instruction fetch responder: the datapath end of the control-unit interface. On fetch_en_i from the control unit it reads one 32-bit instruction as four byte reads from byte-wide instruction memory. It then presents op/funct and register fields back to the control unit. It also owns the PC register and applies the control unit's PCWrite/Branch/PCSrc commands.

---
 rtl/mips_instr_fetch_if.sv | 12 +
 rtl/mips_instr_fetch.sv | 136 +++++++++++++
 tb/tb_mips_instr_fetch.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_instr_fetch_if.sv
// Byte-wide instruction memory read bus between the fetch unit (master) and memory (slave).
interface mips_instr_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_rdata_i;
  logic              mem_ack_i;

  modport master (output mem_req_o, mem_addr_o, input mem_rdata_i, mem_ack_i);
  modport slave  (input mem_req_o, mem_addr_o, output mem_rdata_i, mem_ack_i);
endinterface

// File: rtl/mips_instr_fetch.sv
// Multicycle MIPS fetch: four big-endian byte reads per instruction, PC register and next-PC mux.
// Optional FETCH_TIMEOUT_EN: abort a fetch that waits TIMEOUT_CYC cycles without an ack.
module mips_instr_fetch #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fetch_en_i,
  input  logic                PCWrite_i,
  input  logic                Branch_i,
  input  logic                zero_i,
  input  logic [1:0]          PCSrc_i,
  input  logic [ADDR_W-1:0]   alu_result_i,
  input  logic [ADDR_W-1:0]   alu_out_i,
  mips_instr_fetch_if.master  mem,
  output logic                busy_o,
  output logic                instr_valid_o,
  output logic [31:0]         instr_o,
  output logic [5:0]          op_o,
  output logic [5:0]          funct_o,
  output logic [4:0]          rs_o,
  output logic [4:0]          rt_o,
  output logic [4:0]          rd_o,
  output logic [15:0]         imm_o,
  output logic [ADDR_W-1:0]   pc_o,
  output logic                fetch_err_o
);

  if (ADDR_W < 8 || ADDR_W > 32 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mips_instr_fetch: ADDR_W must be 8..32 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, COMMIT} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q, pc_d, base_q, jump_tgt;
  logic [31:0]       instr_q, shadow_q;
  logic [1:0]        idx_q;
  logic              valid_q, pc_we;
  logic [3:0]        pc_hi;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_q;
  logic             err_q;
`endif

  // Jump target is built as the 32-bit MIPS value, then truncated to the PC width.
  assign pc_hi    = 4'(32'(pc_q) >> 28);
  assign jump_tgt = ADDR_W'({pc_hi, instr_q[25:0], 2'b00});

  always_comb begin
    pc_we = (PCWrite_i | (Branch_i & zero_i)) && (PCSrc_i != 2'b11);
    pc_d  = pc_q;
    case (PCSrc_i)
      2'b00:   pc_d = alu_result_i;
      2'b01:   pc_d = alu_out_i;
      2'b10:   pc_d = jump_tgt;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      base_q   <= '0;
      instr_q  <= '0;
      shadow_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      // PC updates are independent of the fetch; the fetch addresses from base_q.
      if (pc_we) pc_q <= pc_d;
      case (state_q)
        IDLE: if (fetch_en_i) begin
          base_q  <= pc_q;
          idx_q   <= '0;
          state_q <= REQ;
`ifdef FETCH_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        REQ: if (mem.mem_ack_i) begin
`ifdef FETCH_TIMEOUT_EN
          tmo_q <= '0;
`endif
          if (idx_q == 2'd3) begin
            instr_q <= {shadow_q[31:8], mem.mem_rdata_i};
            valid_q <= 1'b1;
            state_q <= COMMIT;
          end else begin
            shadow_q[{~idx_q, 3'b000} +: 8] <= mem.mem_rdata_i;
            idx_q <= idx_q + 2'd1;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
`endif
        COMMIT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_req_o  = (state_q == REQ);
  assign mem.mem_addr_o = base_q + ADDR_W'(idx_q);
  assign busy_o         = (state_q != IDLE);
  assign instr_valid_o  = valid_q;
  assign instr_o        = instr_q;
  assign op_o           = instr_q[31:26];
  assign rs_o           = instr_q[25:21];
  assign rt_o           = instr_q[20:16];
  assign rd_o           = instr_q[15:11];
  assign funct_o        = instr_q[5:0];
  assign imm_o          = instr_q[15:0];
  assign pc_o           = pc_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err_o    = err_q;
`else
  assign fetch_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_mips_instr_fetch.sv
// Scoreboard bench for mips_instr_fetch: byte memory model, PC model and per-cycle output checks.
module tb_mips_instr_fetch;
  localparam int AW = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic fetch_en = 0, pcw = 0, br = 0, z = 0;
  logic [1:0] src = 2'b11;
  logic [AW-1:0] alu_result = '0, alu_out = '0;
  logic busy, ivalid, ferr;
  logic [31:0] instr;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm;
  logic [AW-1:0] pc;

  mips_instr_fetch_if #(.ADDR_W(AW)) bus ();

  mips_instr_fetch #(.ADDR_W(AW), .RESET_PC('0), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .rst_i(rst), .fetch_en_i(fetch_en), .PCWrite_i(pcw), .Branch_i(br),
    .zero_i(z), .PCSrc_i(src), .alu_result_i(alu_result), .alu_out_i(alu_out), .mem(bus),
    .busy_o(busy), .instr_valid_o(ivalid), .instr_o(instr), .op_o(op), .funct_o(funct),
    .rs_o(rs), .rt_o(rt), .rd_o(rd), .imm_o(imm), .pc_o(pc), .fetch_err_o(ferr));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, valid_cyc = 0, ack_cnt = 0, dly_fixed = -1;
  bit mute = 0, fetching = 0;
  logic [7:0]    mem [256];
  logic [31:0]   instr_q [$];
  logic [AW-1:0] addr_q [$];
  logic [31:0]   instr_m = '0;
  logic [AW-1:0] pc_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference PC: "if written and source isn't hold, take the selected value".
  function automatic logic [AW-1:0] pc_next(input logic [AW-1:0] p);
    if (!(pcw || (br && z)) || src == 2'b11) return p;
    if (src == 2'b00) return alu_result;
    if (src == 2'b01) return alu_out;
    return AW'(instr_m << 2);
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) pc_m <= '0;
    else     pc_m <= pc_next(pc_m);

  // Memory responder: checks the address against the expected sequence and acks after a delay.
  initial begin : responder
    int wait_left = -1;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      if (rst || !bus.mem_req_o) wait_left = -1;
      else begin
        if (addr_q.size() == 0) chk("unexpected_req", 32'(bus.mem_addr_o), 32'hFFFF_FFFF);
        else chk("mem_addr", 32'(bus.mem_addr_o), 32'(addr_q[0]));
        if (!mute) begin
          if (wait_left < 0) wait_left = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(0, 2));
          if (wait_left == 0) begin
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = mem[bus.mem_addr_o];
            if (addr_q.size() != 0) void'(addr_q.pop_front());
            ack_cnt++;
            wait_left = -1;
          end else wait_left--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each commit, checks held outputs every cycle.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ivalid) begin
          if (instr_q.size() == 0) chk("unexpected_valid", 32'(ivalid), 32'd0);
          else begin
            instr_m   = instr_q.pop_front();
            fetching  = 0;
            valid_cyc = cyc;
          end
        end
        chk("instr", instr, instr_m);
        chk("op", 32'(op), 32'(instr_m >> 26));
        chk("funct", 32'(funct), instr_m & 32'h3F);
        chk("rs", 32'(rs), (instr_m >> 21) & 32'h1F);
        chk("rt", 32'(rt), (instr_m >> 16) & 32'h1F);
        chk("rd", 32'(rd), (instr_m >> 11) & 32'h1F);
        chk("imm", 32'(imm), instr_m & 32'hFFFF);
        chk("pc", 32'(pc), 32'(pc_m));
        if (!fetching) chk("req_idle", 32'(bus.mem_req_o), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_fetch();
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++) begin
      w = (w << 8) | 32'(mem[8'(pc_m + AW'(k))]);
      addr_q.push_back(pc_m + AW'(k));
    end
    instr_q.push_back(w);
    fetching = 1;
    fetch_en = 1;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (fetching && b < 200) begin tick(); b++; end
    if (fetching) begin
      chk("fetch_timeout", 32'(fetching), 32'd0);
      fetching = 0; instr_q.delete(); addr_q.delete();
    end
  endtask

  task automatic pc_cmd(input logic w, input logic b, input logic zz, input logic [1:0] s,
                        input logic [AW-1:0] r, input logic [AW-1:0] o);
    pcw = w; br = b; z = zz; src = s; alu_result = r; alu_out = o;
    tick();
    pcw = 0; br = 0; z = 0; src = 2'b11;
  endtask

  task automatic do_reset();
    rst = 1; fetch_en = 0; fetching = 0; mute = 0;
    instr_q.delete(); addr_q.delete(); instr_m = '0;
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(ivalid), 32'd0);
    chk("rst_err", 32'(ferr), 32'd0);
    tick(); rst = 0; tick();
  endtask

  initial begin
    int c0, a0, b;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hAC; mem[1] = 8'h11; mem[2] = 8'h00; mem[3] = 8'h04;
    mem[8'h10] = 8'h00; mem[8'h11] = 8'h85; mem[8'h12] = 8'h10; mem[8'h13] = 8'h22;
    #2;
    do_reset();

    // Zero-wait fetch from 0: latency 5.
    dly_fixed = 0;
    start_fetch(); c0 = cyc; tick(); fetch_en = 0;
    wait_idle();
    chk("latency", 32'(valid_cyc - c0), 32'd5);
    chk("instr0", instr, 32'hAC110004);
    chk("op0", 32'(op), 32'h2B);
    chk("rt0", 32'(rt), 32'h11);
    chk("imm0", 32'(imm), 32'h0004);

    // PC commands.
    pc_cmd(1, 0, 0, 2'b00, 8'h04, 8'h00); chk("pc_write", 32'(pc), 32'h04);
    pc_cmd(0, 1, 0, 2'b01, 8'h00, 8'h77); chk("pc_br_nt", 32'(pc), 32'h04);
    pc_cmd(0, 1, 1, 2'b01, 8'h00, 8'h20); chk("pc_br_t", 32'(pc), 32'h20);
    pc_cmd(1, 0, 0, 2'b11, 8'h55, 8'h66); chk("pc_hold", 32'(pc), 32'h20);
    pc_cmd(1, 0, 0, 2'b10, 8'h00, 8'h00); chk("pc_jump", 32'(pc), 32'h10);

    // Slow R-type fetch at 0x10 with PC moved mid-fetch.
    dly_fixed = 2;
    a0 = ack_cnt;
    start_fetch(); tick(); fetch_en = 0;
    b = 0;
    while (ack_cnt < a0 + 1 && b < 50) begin tick(); b++; end
    pc_cmd(1, 0, 0, 2'b00, 8'h40, 8'h00);
    chk("pc_mid_fetch", 32'(pc), 32'h40);
    wait_idle();
    chk("instr_r", instr, 32'h00851022);
    chk("funct_r", 32'(funct), 32'h22);
    chk("rd_r", 32'(rd), 32'd2);

    // Wrap-around fetch at 0xFE.
    dly_fixed = -1;
    pc_cmd(1, 0, 0, 2'b00, 8'hFE, 8'h00);
    start_fetch(); tick(); fetch_en = 0;
    wait_idle();

    // Reset after the second ack, then refetch from RESET_PC.
    pc_cmd(1, 0, 0, 2'b00, 8'h30, 8'h00);
    a0 = ack_cnt;
    start_fetch(); tick(); fetch_en = 0;
    b = 0;
    while (ack_cnt < a0 + 2 && b < 50) begin tick(); b++; end
    do_reset();
    dly_fixed = 0;
    start_fetch(); tick(); fetch_en = 0;
    wait_idle();
    chk("refetch", instr, 32'hAC110004);

`ifdef FETCH_TIMEOUT_EN
    mute = 1;
    start_fetch(); tick(); fetch_en = 0;
    b = 0;
    while (!ferr && b < 40) begin tick(); b++; end
    chk("tmo_err", 32'(ferr), 32'd1);
    chk("tmo_req", 32'(bus.mem_req_o), 32'd0);
    chk("tmo_instr", instr, 32'hAC110004);
    fetching = 0; instr_q.delete(); addr_q.delete();
    tick(); tick();
    chk("tmo_sticky", 32'(ferr), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    do_reset();
`endif

    // Random phase.
    dly_fixed = -1;
    repeat (600) begin
      pcw = ($urandom_range(0, 7) == 0); br = ($urandom_range(0, 3) == 0); z = 1'($urandom);
      src = 2'($urandom); alu_result = AW'($urandom); alu_out = AW'($urandom);
      if (!fetching && $urandom_range(0, 2) == 0) start_fetch();
      else fetch_en = fetching && ($urandom_range(0, 4) == 0);
      tick();
    end
    fetch_en = 0; pcw = 0; br = 0; src = 2'b11;
    wait_idle();
    tick();
`ifndef FETCH_TIMEOUT_EN
    chk("err_tied", 32'(ferr), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end
endmodule
